// File: rtl/pwm_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : pwm_tick_gen
// Brief    : Tick-advanced PWM generator with period/duty double-buffered and
//            applied only at period boundaries (glitch-free output).
// Revision : 1.0  initial release
// ============================================================================
module pwm_tick_gen #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_en,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] period,
    input  logic [WIDTH-1:0] duty,
    output logic             pwm_out,
    output logic             period_end,
    output logic             load_ack
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_per_sh;
    logic [WIDTH-1:0] r_duty_sh;
    logic [WIDTH-1:0] r_per_pend;
    logic [WIDTH-1:0] r_duty_pend;
    logic             r_pend;

    logic             w_active;
    logic             w_wrap;
    logic             w_bypass;
    logic             w_apply;
    logic [WIDTH-1:0] w_cnt_next;
    logic [WIDTH-1:0] w_per_next;
    logic [WIDTH-1:0] w_duty_next;
    logic             w_pend_next;
    logic             w_pwm_next;

    assign w_active = (r_state == S_RUN) || (r_state == S_DRAIN);
    assign w_wrap   = w_active && tick_en && (r_cnt == r_per_sh);
    // A load landing on the wrap tick bypasses the pending registers.
    assign w_bypass = w_wrap && load;
    assign w_apply  = w_active ? (w_wrap && (r_pend || load)) : r_pend;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_RUN, S_DRAIN: begin
                if (w_wrap && !enable) begin
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = enable ? S_RUN : S_DRAIN;
                end
            end
            default: begin
                w_state_next = enable ? S_RUN : S_IDLE;
            end
        endcase
    end

    always_comb begin
        w_per_next  = r_per_sh;
        w_duty_next = r_duty_sh;
        if (w_apply) begin
            w_per_next  = w_bypass ? period : r_per_pend;
            w_duty_next = w_bypass ? duty   : r_duty_pend;
        end

        w_pend_next = r_pend;
        if (w_bypass) begin
            w_pend_next = 1'b0;
        end else if (load) begin
            w_pend_next = 1'b1;
        end else if (w_apply) begin
            w_pend_next = 1'b0;
        end

        w_cnt_next = r_cnt;
        w_pwm_next = pwm_out;
        if (!w_active) begin
            w_cnt_next = '0;
            w_pwm_next = enable && (w_duty_next != '0);
        end else if (tick_en) begin
            w_cnt_next = w_wrap ? '0 : WIDTH'(r_cnt + 1'b1);
            if (w_state_next == S_IDLE) begin
                w_pwm_next = 1'b0;
            end else begin
                w_pwm_next = (w_cnt_next < w_duty_next);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= '0;
            r_per_sh    <= '0;
            r_duty_sh   <= '0;
            r_per_pend  <= '0;
            r_duty_pend <= '0;
            r_pend      <= 1'b0;
            pwm_out     <= 1'b0;
            period_end  <= 1'b0;
            load_ack    <= 1'b0;
        end else begin
            r_cnt      <= w_cnt_next;
            r_per_sh   <= w_per_next;
            r_duty_sh  <= w_duty_next;
            r_pend     <= w_pend_next;
            pwm_out    <= w_pwm_next;
            period_end <= w_wrap;
            load_ack   <= w_apply;
            if (load) begin
                r_per_pend  <= period;
                r_duty_pend <= duty;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pwm_tick_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_pwm_tick_gen
// Brief    : Scoreboard bench for pwm_tick_gen against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_pwm_tick_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_en;
    logic       enable;
    logic       load;
    logic [7:0] period;
    logic [7:0] duty;
    logic       pwm_out;
    logic       period_end;
    logic       load_ack;

    always #5 clk = ~clk;

    pwm_tick_gen #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .tick_en    (tick_en),
        .enable     (enable),
        .load       (load),
        .period     (period),
        .duty       (duty),
        .pwm_out    (pwm_out),
        .period_end (period_end),
        .load_ack   (load_ack)
    );

    typedef struct packed {
        logic pwm;
        logic pe;
        logic ack;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   div = 0;

    // Reference model: active flag, position in period, shadow and pending values.
    bit   m_active;
    int   m_cnt, m_P, m_D, m_pP, m_dP;
    bit   m_pend, m_pwm, m_pe, m_ack;

    task automatic model_reset();
        m_active = 0; m_cnt = 0; m_P = 0; m_D = 0; m_pP = 0; m_dP = 0;
        m_pend = 0; m_pwm = 0; m_pe = 0; m_ack = 0;
    endtask

    task automatic model_store_pending();
        m_pP = period; m_dP = duty; m_pend = 1;
    endtask

    task automatic model_step();
        m_pe = 0; m_ack = 0;
        if (!m_active) begin
            m_cnt = 0;
            if (m_pend) begin
                m_P = m_pP; m_D = m_dP; m_pend = 0; m_ack = 1;
            end
            if (load) model_store_pending();
            m_active = enable;
            m_pwm = enable && (m_D > 0);
        end else if (tick_en) begin
            if (m_cnt == m_P) begin
                m_cnt = 0; m_pe = 1;
                if (load) begin
                    m_P = period; m_D = duty; m_pend = 0; m_ack = 1;
                end else if (m_pend) begin
                    m_P = m_pP; m_D = m_dP; m_pend = 0; m_ack = 1;
                end
                m_active = enable;
                m_pwm = enable && (m_D > 0);
            end else begin
                m_cnt = m_cnt + 1;
                m_pwm = (m_cnt < m_D);
                if (load) model_store_pending();
            end
        end else if (load) begin
            model_store_pending();
        end
    endtask

    task automatic step(input logic tk, input logic en, input logic ld,
                        input int p, input int d);
        @(negedge clk);
        tick_en = tk; enable = en; load = ld;
        period = 8'(p); duty = 8'(d);
        model_step();
        q.push_back('{pwm: m_pwm, pe: m_pe, ack: m_ack});
    endtask

    // Directed phases use a 1-in-5 tick like the upstream divider.
    task automatic step_div(input logic en, input logic ld, input int p, input int d);
        step(div == 4, en, ld, p, d);
        div = (div + 1) % 5;
    endtask

    task automatic run(input int n, input logic en);
        for (int i = 0; i < n; i++) step_div(en, 1'b0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        tick_en = 0; enable = 0; load = 0;
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({pwm_out, period_end, load_ack} !== 3'b000) begin
            miscompares++;
            $display("FAIL async_reset: got pwm/pe/ack=%b%b%b expected 000",
                     pwm_out, period_end, load_ack);
        end
        q.delete();
        model_reset();
        @(negedge clk);
        reset = 1'b0;
        div = 0;
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            vectors++;
            if ({pwm_out, period_end, load_ack} !== e) begin
                miscompares++;
                $display("FAIL cycle_out @%0t: got pwm/pe/ack=%b%b%b expected %b%b%b",
                         $time, pwm_out, period_end, load_ack, e.pwm, e.pe, e.ack);
            end
        end
    end

    initial begin
        reset = 1'b1; tick_en = 0; enable = 0; load = 0; period = 0; duty = 0;
        model_reset();
        #3;
        vectors++;
        if ({pwm_out, period_end, load_ack} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_state: got pwm/pe/ack=%b%b%b expected 000",
                     pwm_out, period_end, load_ack);
        end
        @(negedge clk);
        reset = 1'b0;

        // Basic P=4 D=2 waveform
        step_div(1'b0, 1'b1, 4, 2);
        run(60, 1'b1);

        // Duty change mid-period, applied at the wrap
        run(7, 1'b1);
        step_div(1'b1, 1'b1, 4, 4);
        run(40, 1'b1);

        // Duty extremes
        step_div(1'b1, 1'b1, 4, 0);
        run(40, 1'b1);
        step_div(1'b1, 1'b1, 4, 9);
        run(40, 1'b1);
        step_div(1'b1, 1'b1, 4, 2);
        run(20, 1'b1);

        // Enable drop at cnt=1, re-raise during drain, then full drain to idle
        for (int i = 0; i < 100 && !(m_active && m_cnt == 1); i++) step_div(1'b1, 1'b0, 0, 0);
        for (int i = 0; i < 100 && !(m_cnt == 3); i++) step_div(1'b0, 1'b0, 0, 0);
        run(20, 1'b1);
        for (int i = 0; i < 100 && !(m_active && m_cnt == 1); i++) step_div(1'b1, 1'b0, 0, 0);
        run(40, 1'b0);

        // Asynchronous reset mid-period with output high; pending load discarded
        step_div(1'b1, 1'b1, 4, 3);
        for (int i = 0; i < 100 && !(m_active && m_cnt == 1 && m_pwm); i++) step_div(1'b1, 1'b0, 0, 0);
        step_div(1'b1, 1'b1, 7, 7);
        do_reset();
        run(30, 1'b1);
        run(10, 1'b0);

        // Load coincident with the wrap tick
        step_div(1'b0, 1'b1, 4, 2);
        run(10, 1'b1);
        for (int i = 0; i < 100 && !(div == 4 && m_active && m_cnt == m_P); i++) step_div(1'b1, 1'b0, 0, 0);
        step_div(1'b1, 1'b1, 2, 1);
        run(40, 1'b1);

        // Randomized traffic, small periods so wraps and applies are frequent
        for (int i = 0; i < 2500; i++) begin
            logic tk, en, ld;
            tk = ($urandom_range(0, 2) == 0);
            en = ($urandom_range(0, 15) != 0);
            ld = ($urandom_range(0, 12) == 0);
            step(tk, en, ld, $urandom_range(0, 6), $urandom_range(0, 8));
        end
        run(5, 1'b0);

        @(negedge clk);
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
